// File: rtl/tx_word_serializer_if.sv
// tx_word_serializer_if: buffer-side and UART-side
// signals of the word serializer.
interface tx_word_serializer_if #(
  parameter int WORD_W = 128,
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 16
);
  logic [WORD_W-1:0] din;
  logic              buffer_empty;
  logic              buffer_read;
  logic              tx_done;
  logic              tx_start;
  logic [SYM_W-1:0]  dout;
  logic              busy;
  logic              word_done;
  logic [CNT_W-1:0]  words_sent;

  modport master (
    input  din,
    input  buffer_empty,
    input  tx_done,
    output buffer_read,
    output tx_start,
    output dout,
    output busy,
    output word_done,
    output words_sent
  );

  modport slave (
    output din,
    output buffer_empty,
    output tx_done,
    input  buffer_read,
    input  tx_start,
    input  dout,
    input  busy,
    input  word_done,
    input  words_sent
  );
endinterface

// File: rtl/tx_word_serializer.sv
// tx_word_serializer: pops one buffered word and sends it
// symbol by symbol over a tx_start/tx_done handshake.
module tx_word_serializer #(
  parameter int WORD_W    = 128,
  parameter int SYM_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  reset,
  tx_word_serializer_if.master bus
);
  localparam int NSYM  = WORD_W / SYM_W;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSYM - 1);

  typedef enum logic [2:0] {
    IDLE, RD, LOAD, SEND, WAIT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_sh;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              rd_q;
  logic              start_q;
  logic              busy_q;
  logic              done_q;
  logic              acc;
  logic              last_done;

  assign acc       = (state == WAIT) && bus.tx_done;
  assign last_done = acc && (idx == LAST);
  assign sr_sh     = MSB_FIRST ? (sr << SYM_W)
                               : (sr >> SYM_W);

  assign bus.buffer_read = rd_q;
  assign bus.tx_start    = start_q;
  assign bus.busy        = busy_q;
  assign bus.word_done   = done_q;
  assign bus.words_sent  = cnt;
  assign bus.dout        = MSB_FIRST
                         ? sr[WORD_W-1 -: SYM_W]
                         : sr[SYM_W-1:0];

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state; tx_done only counts while waiting
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!bus.buffer_empty) state_nx = RD;
      RD:   state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: state_nx = WAIT;
      WAIT: begin
        if (bus.tx_done)
          state_nx = (idx == LAST) ? IDLE : SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  // word capture, symbol shift and sent-word count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (state == LOAD) begin
      sr  <= bus.din;
      idx <= '0;
    end else if (last_done) begin
      cnt <= cnt + CNT_W'(1);
    end else if (acc) begin
      sr  <= sr_sh;
      idx <= idx + IDX_W'(1);
    end
  end

  // strobes and status registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q    <= (state_nx == RD);
      start_q <= (state_nx == SEND);
      busy_q  <= (state_nx != IDLE);
      done_q  <= last_done;
    end
  end
endmodule

// File: tb/tb_tx_word_serializer.sv
// tb_tx_word_serializer: scoreboard bench with buffer and
// UART models across three parameter sets.
module tb_tx_word_serializer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_word_serializer_if #(
    .WORD_W(128), .SYM_W(8), .CNT_W(16)) b0 ();
  tx_word_serializer_if #(
    .WORD_W(128), .SYM_W(8), .CNT_W(2)) b1 ();
  tx_word_serializer_if #(
    .WORD_W(32), .SYM_W(8), .CNT_W(16)) b2 ();

  tx_word_serializer #(
    .WORD_W(128), .SYM_W(8),
    .MSB_FIRST(1'b1), .CNT_W(16)
  ) u0 (.clk(clk), .reset(rst_n), .bus(b0));

  tx_word_serializer #(
    .WORD_W(128), .SYM_W(8),
    .MSB_FIRST(1'b0), .CNT_W(2)
  ) u1 (.clk(clk), .reset(rst_n), .bus(b1));

  tx_word_serializer #(
    .WORD_W(32), .SYM_W(8),
    .MSB_FIRST(1'b1), .CNT_W(16)
  ) u2 (.clk(clk), .reset(rst_n), .bus(b2));

  localparam logic [127:0] W1 =
    128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W2 =
    128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] W3 =
    128'h5A5AC3C30F0F9696A5A53C3CF0F06969;

  logic [127:0] din_r = '0;
  logic [127:0] fq[$];
  logic [7:0]   sbq[$];
  int act = 0;
  int dly = 5;
  int spmode = 0;
  bit chk_gap = 1'b0;
  int gap_base = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic md[3];
  logic sp[3] = '{1'b0, 1'b0, 1'b0};
  logic emp[3];
  logic ldp = 1'b0;
  int   ucnt[3];

  logic       ts[3];
  logic       br[3];
  logic       bsy[3];
  logic       wd[3];
  logic [7:0] dq[3];
  logic [15:0] ws[3];

  int nts[3];
  int nbr[3];
  int nwd[3];
  int last_dn[3];
  logic [7:0] hold[3];
  bit infl[3];
  bit neww[3];

  assign b0.din = din_r;
  assign b1.din = din_r;
  assign b2.din = din_r[31:0];
  assign b0.buffer_empty = emp[0];
  assign b1.buffer_empty = emp[1];
  assign b2.buffer_empty = emp[2];
  assign b0.tx_done = md[0] | sp[0];
  assign b1.tx_done = md[1] | sp[1];
  assign b2.tx_done = md[2] | sp[2];

  assign ts[0]  = b0.tx_start;
  assign ts[1]  = b1.tx_start;
  assign ts[2]  = b2.tx_start;
  assign br[0]  = b0.buffer_read;
  assign br[1]  = b1.buffer_read;
  assign br[2]  = b2.buffer_read;
  assign bsy[0] = b0.busy;
  assign bsy[1] = b1.busy;
  assign bsy[2] = b2.busy;
  assign wd[0]  = b0.word_done;
  assign wd[1]  = b1.word_done;
  assign wd[2]  = b2.word_done;
  assign dq[0]  = b0.dout;
  assign dq[1]  = b1.dout;
  assign dq[2]  = b2.dout;
  assign ws[0]  = b0.words_sent;
  assign ws[1]  = {14'b0, b1.words_sent};
  assign ws[2]  = b2.words_sent;

  task automatic chk(input string nm,
                     input longint got,
                     input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               nm, got, want);
    end
  endtask

  task automatic exp_syms(input logic [127:0] w,
                          input int nsym,
                          input bit msb);
    logic [7:0] s;
    for (int i = 0; i < nsym; i++) begin
      s = msb ? w[8*(nsym-1-i) +: 8] : w[8*i +: 8];
      sbq.push_back(s);
    end
  endtask

  task automatic exp_word(input logic [127:0] w,
                          input int nsym,
                          input bit msb);
    exp_syms(w, nsym, msb);
    fq.push_back(w);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((sbq.size() != 0 || fq.size() != 0 ||
            bsy[act]) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", longint'(n < lim), 1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  // cycle count for gap measurement
  always @(posedge clk) cyc <= cyc + 1;

  // buffer pops and UART tx_done replies
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        md[k]   <= 1'b0;
        ucnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        md[k] <= 1'b0;
        if (ts[k]) ucnt[k] <= dly;
        else if (ucnt[k] > 0) begin
          ucnt[k] <= ucnt[k] - 1;
          if (ucnt[k] == 1) md[k] <= 1'b1;
        end
        if (br[k] && act == k && fq.size() > 0)
          din_r <= fq.pop_front();
      end
    end
    for (int k = 0; k < 3; k++)
      emp[k] <= !(act == k && fq.size() > 0);
  end

  // spurious tx_done: toggling, or idle/load/start
  always @(negedge clk) begin
    sp[1] <= 1'b0;
    sp[2] <= 1'b0;
    if (spmode == 1)
      sp[0] <= ~sp[0];
    else if (spmode == 2)
      sp[0] <= !bsy[0] || ts[0] || ldp;
    else
      sp[0] <= 1'b0;
    ldp <= (spmode == 2) && br[0];
  end

  // monitor: pops the scoreboard on every tx_start
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        infl[k] = 1'b0;
        neww[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (br[k]) begin
          nbr[k]++;
          neww[k] = 1'b1;
        end
        if (wd[k]) begin
          nwd[k]++;
          chk("done_not_busy", bsy[k], 0);
        end
        if (ts[k]) begin
          nts[k]++;
          if (chk_gap && neww[k] &&
              nbr[k] > gap_base + 1)
            chk("word_gap", cyc - last_dn[k], 4);
          neww[k] = 1'b0;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_symbol dut%0d got=%02h want=none",
                     k, dq[k]);
          end else begin
            chk("symbol", dq[k], sbq.pop_front());
          end
          hold[k] = dq[k];
          infl[k] = 1'b1;
        end else if (infl[k]) begin
          chk("dout_hold", dq[k], hold[k]);
          if (md[k]) begin
            infl[k]    = 1'b0;
            last_dn[k] = cyc;
          end
        end
      end
    end
  end

  initial begin
    int c;
    int b_ts;
    int b_br;
    rst_n  = 1'b0;
    spmode = 1;
    exp_word(W1, 16, 1'b1);
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("rst_ctl",
          {ts[0], br[0], bsy[0], wd[0]}, 0);
      chk("rst_dout", dq[0], 0);
      chk("rst_cnt", ws[0], 0);
    end
    spmode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rd_after_rst", br[0], 1);
    @(negedge clk);
    #2;
    chk("load_quiet", {ts[0], br[0]}, 0);
    @(negedge clk);
    #2;
    chk("first_start", ts[0], 1);
    drain(500);
    chk("w1_done", nwd[0], 1);
    chk("w1_count", ws[0], 1);
    chk("w1_syms", nts[0], 16);

    dly      = 1;
    b_ts     = nts[0];
    b_br     = nbr[0];
    gap_base = nbr[0];
    chk_gap  = 1'b1;
    exp_word(W2, 16, 1'b1);
    exp_word(W1, 16, 1'b1);
    exp_word(W3, 16, 1'b1);
    drain(600);
    chk_gap = 1'b0;
    chk("b2b_reads", nbr[0] - b_br, 3);
    chk("b2b_starts", nts[0] - b_ts, 48);
    chk("b2b_count", ws[0], 4);

    dly    = 3;
    spmode = 2;
    b_ts   = nts[0];
    repeat (3) @(negedge clk);
    #2;
    exp_word(W3, 16, 1'b1);
    drain(800);
    spmode = 0;
    chk("spur_starts", nts[0] - b_ts, 16);
    chk("spur_count", ws[0], 5);

    dly  = 2;
    b_ts = nts[0];
    exp_word(W2, 16, 1'b1);
    fq.push_back(W1);
    c = 0;
    for (int n = 0; n < 400 && c < 7; n++) begin
      @(negedge clk);
      #2;
      if (md[0]) c++;
    end
    chk("abort_reached", c, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_left", sbq.size(), 9);
    chk("abort_start_low", ts[0], 0);
    sbq.delete();
    exp_syms(W1, 16, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    chk("abort_rst_ctl", {ts[0], bsy[0]}, 0);
    chk("abort_rst_cnt", ws[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain(600);
    chk("abort_starts", nts[0] - b_ts, 23);
    chk("abort_count", ws[0], 1);

    act = 1;
    dly = 1;
    exp_word(W1, 16, 1'b0);
    exp_word(W2, 16, 1'b0);
    exp_word(W3, 16, 1'b0);
    exp_word(W1, 16, 1'b0);
    exp_word(W2, 16, 1'b0);
    drain(1500);
    chk("lsb_words", nwd[1], 5);
    chk("wrap_count", ws[1], 1);

    act = 2;
    dly = 2;
    sbq.push_back(8'hDE);
    sbq.push_back(8'hAD);
    sbq.push_back(8'hBE);
    sbq.push_back(8'hEF);
    fq.push_back(128'hDEADBEEF);
    drain(300);
    chk("w32_starts", nts[2], 4);
    chk("w32_count", ws[2], 1);
    chk("w32_done", nwd[2], 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
